// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, ALU
// operation codes, datapath select codes and opcode/funct constants.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        BR_EQ  = 2'd0,
        BR_NE  = 2'd1,
        BR_GEZ = 2'd2,
        BR_LTZ = 2'd3
    } br_t;

    localparam logic [4:0] ALU_NOP  = 5'd0;
    localparam logic [4:0] ALU_LUI  = 5'd1;
    localparam logic [4:0] ALU_ADD  = 5'd2;
    localparam logic [4:0] ALU_SUB  = 5'd3;
    localparam logic [4:0] ALU_ADDU = 5'd4;
    localparam logic [4:0] ALU_SUBU = 5'd5;
    localparam logic [4:0] ALU_AND  = 5'd6;
    localparam logic [4:0] ALU_OR   = 5'd7;
    localparam logic [4:0] ALU_NOR  = 5'd8;
    localparam logic [4:0] ALU_XOR  = 5'd9;
    localparam logic [4:0] ALU_SLT  = 5'd10;
    localparam logic [4:0] ALU_SLTU = 5'd11;
    localparam logic [4:0] ALU_SLL  = 5'd12;
    localparam logic [4:0] ALU_SRL  = 5'd13;
    localparam logic [4:0] ALU_SRA  = 5'd14;
    localparam logic [4:0] ALU_SLLV = 5'd15;
    localparam logic [4:0] ALU_SRLV = 5'd16;
    localparam logic [4:0] ALU_SRAV = 5'd17;

    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;

    localparam logic [1:0] WDSEL_ALU = 2'd0;
    localparam logic [1:0] WDSEL_MEM = 2'd1;
    localparam logic [1:0] WDSEL_PC  = 2'd2;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] SRCB_RD2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// Combinational instruction decoder: maps latched Op/Funct/Rt to the ALU
// operation, immediate handling and the instruction class flags.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic [4:0] Rt,
    output logic [4:0] alu_op,
    output logic       ext_op,
    output logic [1:0] src_b,
    output br_t        br_kind,
    output logic       is_rtype,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jump,
    output logic       is_link,
    output logic       ovf_chk,
    output logic       is_illegal
);

    always_comb begin
        alu_op     = ALU_NOP;
        ext_op     = 1'b0;
        src_b      = SRCB_RD2;
        br_kind    = BR_EQ;
        is_rtype   = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        is_link    = 1'b0;
        ovf_chk    = 1'b0;
        is_illegal = 1'b0;
        case (Op)
            OP_RTYPE: begin
                is_rtype = 1'b1;
                case (Funct)
                    FUNCT_ADD:  begin alu_op = ALU_ADD; ovf_chk = 1'b1; end
                    FUNCT_ADDU: alu_op = ALU_ADDU;
                    FUNCT_SUB:  begin alu_op = ALU_SUB; ovf_chk = 1'b1; end
                    FUNCT_SUBU: alu_op = ALU_SUBU;
                    FUNCT_AND:  alu_op = ALU_AND;
                    FUNCT_OR:   alu_op = ALU_OR;
                    FUNCT_XOR:  alu_op = ALU_XOR;
                    FUNCT_NOR:  alu_op = ALU_NOR;
                    FUNCT_SLT:  alu_op = ALU_SLT;
                    FUNCT_SLTU: alu_op = ALU_SLTU;
                    FUNCT_SLL:  alu_op = ALU_SLL;
                    FUNCT_SRL:  alu_op = ALU_SRL;
                    FUNCT_SRA:  alu_op = ALU_SRA;
                    FUNCT_SLLV: alu_op = ALU_SLLV;
                    FUNCT_SRLV: alu_op = ALU_SRLV;
                    FUNCT_SRAV: alu_op = ALU_SRAV;
                    default:    is_illegal = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                ext_op = 1'b1;
                case (Rt)
                    RT_BLTZ: begin is_branch = 1'b1; br_kind = BR_LTZ; end
                    RT_BGEZ: begin is_branch = 1'b1; br_kind = BR_GEZ; end
                    default: is_illegal = 1'b1;
                endcase
            end
            OP_J:     is_jump = 1'b1;
            OP_JAL:   begin is_jump = 1'b1; is_link = 1'b1; end
            OP_BEQ:   begin alu_op = ALU_SUB; ext_op = 1'b1; is_branch = 1'b1; br_kind = BR_EQ; end
            OP_BNE:   begin alu_op = ALU_SUB; ext_op = 1'b1; is_branch = 1'b1; br_kind = BR_NE; end
            OP_ADDI:  begin alu_op = ALU_ADD;  ext_op = 1'b1; src_b = SRCB_IMM; ovf_chk = 1'b1; end
            OP_ADDIU: begin alu_op = ALU_ADDU; ext_op = 1'b1; src_b = SRCB_IMM; end
            OP_SLTI:  begin alu_op = ALU_SLT;  ext_op = 1'b1; src_b = SRCB_IMM; end
            OP_ANDI:  begin alu_op = ALU_AND;  src_b = SRCB_IMM; end
            OP_ORI:   begin alu_op = ALU_OR;   src_b = SRCB_IMM; end
            OP_LUI:   begin alu_op = ALU_LUI;  src_b = SRCB_IMM; end
            OP_LW:    begin alu_op = ALU_ADDU; ext_op = 1'b1; src_b = SRCB_IMM; is_load = 1'b1; end
            OP_SW:    begin alu_op = ALU_ADDU; ext_op = 1'b1; src_b = SRCB_IMM; is_store = 1'b1; end
            default:  is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM: sequences IF/ID/EX/MEM/WB and drives the datapath
// enables and selects from the current state and the decoded instruction.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter bit TRAP_ON_OVF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic [4:0] Rt,
    input  logic       Zero,
    input  logic       Gez,
    input  logic       Overflow,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [4:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       EXTOp,
    output logic [1:0] RegDst,
    output logic [1:0] WDSel,
    output logic [1:0] NPCOp,
    output logic       ovf_exc,
    output logic       ill_instr,
    output logic [2:0] state
);

    state_t     st;
    logic       hold;
    logic       ovf_q;
    logic [4:0] alu_op;
    logic [1:0] src_b;
    br_t        br_kind;
    logic       ext_op, is_rtype, is_load, is_store, is_branch;
    logic       is_jump, is_link, ovf_chk, is_illegal, br_taken;

    mc_alu_dec u_dec (
        .Op(Op), .Funct(Funct), .Rt(Rt),
        .alu_op(alu_op), .ext_op(ext_op), .src_b(src_b), .br_kind(br_kind),
        .is_rtype(is_rtype), .is_load(is_load), .is_store(is_store),
        .is_branch(is_branch), .is_jump(is_jump), .is_link(is_link),
        .ovf_chk(ovf_chk), .is_illegal(is_illegal)
    );

    // hold keeps every output quiet for the cycle after reset, before the first fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= S_IF;
            hold  <= 1'b1;
            ovf_q <= 1'b0;
        end else if (hold) begin
            hold <= 1'b0;
        end else begin
            case (st)
                S_IF: st <= S_ID;
                S_ID: begin
                    ovf_q <= 1'b0;
                    if (is_illegal)   st <= S_IF;
                    else if (is_jump) st <= is_link ? S_WB : S_IF;
                    else              st <= S_EX;
                end
                S_EX: begin
                    ovf_q <= Overflow & ovf_chk;
                    if (is_branch)                st <= S_IF;
                    else if (is_load || is_store) st <= S_MEM;
                    else                          st <= S_WB;
                end
                S_MEM:   st <= is_store ? S_IF : S_WB;
                S_WB:    st <= S_IF;
                default: st <= S_IF;
            endcase
        end
    end

    always_comb begin
        case (br_kind)
            BR_EQ:   br_taken = Zero;
            BR_NE:   br_taken = ~Zero;
            BR_GEZ:  br_taken = Gez;
            default: br_taken = ~Gez;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        ALUOp     = ALU_NOP;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        EXTOp     = 1'b0;
        RegDst    = REGDST_RT;
        WDSel     = WDSEL_ALU;
        NPCOp     = NPC_PLUS4;
        ovf_exc   = 1'b0;
        ill_instr = 1'b0;
        if (!hold) begin
            case (st)
                S_IF: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    ALUOp   = ALU_ADDU;
                end
                S_ID: begin
                    if (is_illegal) begin
                        ill_instr = 1'b1;
                    end else if (is_jump && !is_link) begin
                        PCWrite = 1'b1;
                        NPCOp   = NPC_JUMP;
                    end
                end
                S_EX: begin
                    ALUOp   = alu_op;
                    ALUSrcA = 1'b1;
                    ALUSrcB = src_b;
                    EXTOp   = ext_op;
                    if (is_branch && br_taken) begin
                        PCWrite = 1'b1;
                        NPCOp   = NPC_BRANCH;
                    end
                end
                S_MEM: MemWrite = is_store;
                S_WB: begin
                    if (TRAP_ON_OVF && ovf_q) ovf_exc  = 1'b1;
                    else                      RegWrite = 1'b1;
                    RegDst = is_link ? REGDST_RA : (is_rtype ? REGDST_RD : REGDST_RT);
                    WDSel  = is_link ? WDSEL_PC  : (is_load  ? WDSEL_MEM : WDSEL_ALU);
                    if (is_link) begin
                        PCWrite = 1'b1;
                        NPCOp   = NPC_JUMP;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = st;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM for the MIPS datapath.
- Initiator side of the ALU control interface: decodes the latched instruction fields and sequences the datapath through IF/ID/EX/MEM/WB.
- Each cycle it drives ALUOp and the operand selects, then consumes the ALU status flags (Zero, Gez, Overflow) to resolve branches and suppress overflowing writebacks.
- Sits between the instruction register and the datapath enables (PC, IR, RF, DM).

Parameters:
- TRAP_ON_OVF, 1, when 1 an ADD/SUB/ADDI overflow suppresses RegWrite and pulses ovf_exc; when 0 overflow is ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- Op  in  6  instr[31:26] from IR
- Funct  in  6  instr[5:0] from IR
- Rt  in  5  instr[20:16] from IR; selects BLTZ/BGEZ under REGIMM
- Zero  in  1  ALU result == 0
- Gez  in  1  ALU result >= 0 (signed)
- Overflow  in  1  ALU signed overflow
- PCWrite  out  1  load PC from NPC
- IRWrite  out  1  load IR from instruction memory
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data memory write enable
- ALUOp  out  5  ALU operation, encodings from ctrl_encode_def.v
- ALUSrcA  out  1  0=PC, 1=RD1
- ALUSrcB  out  2  0=RD2, 1=imm ext, 2=const 4
- EXTOp  out  1  1=sign-extend imm16, 0=zero-extend
- RegDst  out  2  0=rt, 1=rd, 2=$31
- WDSel  out  2  0=ALUOut, 1=MDR, 2=PC
- NPCOp  out  2  0=PC+4, 1=branch, 2=jump
- ovf_exc  out  1  one-cycle pulse on a suppressed overflow write
- ill_instr  out  1  one-cycle pulse on an undecodable opcode
- state  out  3  current FSM state, for debug/verification

Behaviour:
- Reset: state=S_IF. All enables are 0, ALUOp=ALU_NOP, all selects 0, ovf_q=0, and both pulses are 0 in the cycle after rst is sampled high.
- rst has priority over every transition, including mid-instruction. No partial writes complete after reset.
- States: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4.
- Outputs are a Moore function of state plus latched Op/Funct/Rt. Branch PCWrite additionally depends combinationally on Zero/Gez in S_EX.
- S_IF:
  - Drives IRWrite=1, PCWrite=1, NPCOp=0, ALUSrcA=0, ALUSrcB=2, ALUOp=ALU_ADDU.
  - Next state is always S_ID.
- S_ID:
  - No enables asserted.
  - J/JAL: go to S_WB if JAL, otherwise go to S_IF with PCWrite=1, NPCOp=2.
  - Unknown Op (or unknown Funct under Op=0): pulse ill_instr and go to S_IF.
  - Everything else: go to S_EX.
- S_EX ALUOp mapping:
  - R-type: by Funct (ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/SRA/SLLV/SRLV/SRAV).
  - ADDI→ALU_ADD; ADDIU/LW/SW→ALU_ADDU; ANDI/ORI→AND/OR with EXTOp=0; SLTI→ALU_SLT; LUI→ALU_LUI.
  - BEQ/BNE→ALU_SUB; BGEZ/BLTZ→ALU_NOP with ALUSrcA=1.
- S_EX next state and branch resolution:
  - Branch taken condition: BEQ Zero=1; BNE Zero=0; BGEZ Gez=1; BLTZ Gez=0.
  - Taken branch: PCWrite=1, NPCOp=1 in this same cycle. Every branch then returns to S_IF.
  - LW/SW go to S_MEM. All others go to S_WB.
  - ovf_q <= Overflow & (op is ADD, SUB or ADDI), sampled at the end of S_EX.
- S_MEM:
  - SW: MemWrite=1 for exactly one cycle, then go to S_IF.
  - LW: go to S_WB.
- S_WB:
  - RegWrite=1, with select values by instruction:
    - R-type: RegDst=1, WDSel=0.
    - I-type ALU ops: RegDst=0, WDSel=0.
    - LW: RegDst=0, WDSel=1.
    - JAL: RegDst=2, WDSel=2, plus PCWrite=1 and NPCOp=2.
  - If TRAP_ON_OVF and ovf_q: RegWrite=0 and ovf_exc=1.
  - Next state is S_IF.
- Latency in cycles:
  - R/I ALU: 4. LW: 5. SW: 4. Branch: 3. J: 2. JAL: 3.
- Outputs never assert two of RegWrite/MemWrite/IRWrite in the same cycle.

Decomposition:
- Shared package ctrl_encode_def.v gains:
  - State encodings S_IF..S_WB.
  - NPC_PLUS4/NPC_BRANCH/NPC_JUMP, WDSel_* and RegDst_* codes.
  - Opcode/funct constants (OP_RTYPE, OP_REGIMM, FUNCT_*).
  - ALU_* codes are reused unchanged.
- One natural sub-module: mc_alu_dec, a combinational decoder mapping Op/Funct/Rt to ALUOp, EXTOp and class flags (is_rtype, is_load, is_store, is_branch, is_jump, is_link, ovf_chk). mc_ctrl keeps only the FSM.

Test Plan:
- Reset: hold rst 2 cycles mid-S_EX of an ADD → state=0; all enables 0 and ALUOp=ALU_NOP.
- ADD with no overflow (Op=0, Funct=0x20), Overflow=0 → states 0,1,2,4,0. ALUOp=ALU_ADD in S_EX. RegWrite=1, RegDst=1 in S_WB only.
- ADDI with Overflow=1 in S_EX → S_WB has RegWrite=0 and ovf_exc=1 for one cycle. With TRAP_ON_OVF=0, RegWrite=1 and ovf_exc=0.
- LW (0x23) → states 0,1,2,3,4 with ALUOp=ALU_ADDU and WDSel=1. SW (0x2B) → MemWrite=1 only in S_MEM, then back to S_IF.
- Branches:
  - BEQ with Zero=1 → PCWrite=1, NPCOp=1 in S_EX. With Zero=0 → PCWrite=0.
  - BLTZ (Op=1, Rt=0) with Gez=0 → taken. BGEZ (Rt=1) with Gez=0 → not taken.
- Jumps and illegal:
  - JAL (0x03) → S_WB: RegDst=2, WDSel=2, PCWrite=1, NPCOp=2.
  - Op=0x3F → ill_instr pulse in S_ID, then S_IF with no write enables.
